aes_spi_master: RTL and testbench
=================================

// Module: aes_spi_master
// PURPOSE
//  SPI-style serial master between the host-side 128-bit message/key registers and one AES slave
//  (encryption or decryption unit). It repeatedly loads the message and key, shifts them out on Mosi,
//  waits for the slave's start bit on Miso, then shifts the 128-bit result into Sipo_Register.
//  One instance per slave; the decrypt chain is fed from the encrypt chain's Sipo_Register.
// PARAMETERS
//  nk  4   key length in 32-bit words (4/6/8); key width = 32*nk
//  nb  4   block length in 32-bit words; fixed at 4 (128-bit block)
//  nr  10  AES round count; passed through for slave consistency, no effect on master timing
// PORTS
//  in_clk         in   1       system clock, shared with the slave; all logic on rising edge
//  rst            in   1       reset, synchronous, active-high
//  from_Real_msg  in   128     plaintext/ciphertext to send
//  from_Real_key  in   32*nk   cipher key to send
//  Miso           in   1       serial data from slave
//  cs_enc_dec     out  1       chip select to slave, active-low (1 = idle/result valid)
//  Mosi           out  1       serial data to slave
//  out_clk        out  1       transfer clock = in_clk & ~cs_enc_dec (informational)
//  Sipo_Register  out  128     last completed result, MSB = first bit received
// BEHAVIOUR
//  Reset (sync, rst=1 at posedge): state=IDLE, cs_enc_dec=1, Mosi=0, Sipo_Register=0, counters=0.
//   Reset mid-transaction aborts immediately; the slave sees cs rise on the next edge.
//  One serial bit per in_clk cycle. Master drives Mosi on posedge; slave samples on the next posedge.
//  FSM:
//   IDLE: cs=1, Mosi=0, 4 cycles. On the last cycle, latch tx_shift <= {from_Real_msg, from_Real_key}
//    (128+32*nk bits) -> SEND.
//   SEND: cs=0; Mosi = tx_shift MSB, shifted left each cycle; exactly 128+32*nk cycles
//    (256 for nk=4): message MSB first, then key MSB first. Then -> WAIT.
//   WAIT: cs=0, Mosi=0; slave holds Miso=0 while busy. The first cycle with Miso=1 is the start bit
//    -> RECV. After 1024 cycles without a start bit -> IDLE; Sipo_Register unchanged.
//   RECV: cs=0; for 128 cycles rx_shift <= {rx_shift[126:0], Miso}. Then -> DONE.
//   DONE: 1 cycle; Sipo_Register <= rx_shift; cs=1 -> IDLE.
//  Sipo_Register changes only in DONE (or reset). It is stable whenever cs_enc_dec=1, so downstream
//   may capture it while cs_enc_dec=1.
//  Inputs are sampled only at the IDLE->SEND latch; changes during a transaction affect the next one.
//  Operation is free-running (no start input): after DONE/timeout the next transaction begins
//   automatically.
//  Period for nk=4 with slave latency L cycles (WAIT length) = 4+256+L+128+1. This must stay
//   <1600 cycles, which holds for L<=1200.
//  Only nk=4 needs cycle counts verified; nk=6/8 scale SEND length only.
// TESTING
//  1 Reset: hold rst 10 cycles -> cs=1, Mosi=0, out_clk=0, Sipo_Register=0 throughout.
//  2 Send: msg=0x8000_0001_C0DE_0000_FFFF_0000_1234_5678, key=0x8123_4567_89AB_CDEF_0011_2233_4455_6677
//    -> after reset release: cs low 4 cycles later; 256 Mosi bits == {msg,key} MSB first.
//  3 Receive: slave model raises Miso 20 cycles into WAIT, then sends 0x69C4E0D86A7B0430D8CDB78070B4C55A
//    -> Sipo_Register equals it one cycle after bit 128; cs=1 that same cycle.
//  4 Timeout: Miso held 0 -> cs rises after 1024 WAIT cycles; Sipo_Register keeps prior value;
//    next SEND restarts.
//  5 Mid-transaction changes: change msg during SEND -> current bits unaffected; next transaction
//    sends the new msg. Assert rst during RECV -> cs=1 and Sipo_Register=0 next cycle.
//  6 System: encrypt+decrypt masters with slaves, 6 random msg/key pairs, 1600 cycles each
//    -> decrypt Sipo_Register == original msg for all 6.

Source files
------------

// File: rtl/aes_spi_master.sv
// aes_spi_master
// Serial master that feeds one AES slave (encrypt or decrypt unit). It runs a
// free-running loop: idle for 4 cycles, latch {message, key}, shift it out on
// Mosi MSB first, wait for the slave's start bit on Miso, shift 128 result bits
// in, then publish them on Sipo_Register for one DONE cycle and start again.
//
// Handshake: cs_enc_dec is active-low. While cs_enc_dec=1 the transfer is idle
// and Sipo_Register is stable, so downstream logic may capture it any cycle
// cs_enc_dec is high. Mosi is driven on the rising edge and is sampled by the
// slave on the following rising edge; Miso is sampled on every rising edge.
//
// Ports
//   in_clk         system clock (shared with the slave)
//   rst            synchronous, active-high reset
//   from_Real_msg  128-bit block to send
//   from_Real_key  32*nk-bit key to send
//   Miso           serial data from slave
//   cs_enc_dec     chip select to slave, active-low
//   Mosi           serial data to slave
//   out_clk        in_clk gated by chip select (informational only)
//   Sipo_Register  last completed 128-bit result, MSB = first bit received
//   state_dbg      current FSM state: 0 idle, 1 send, 2 wait, 3 recv, 4 done
module aes_spi_master #(
    parameter int nk = 4,
    parameter int nb = 4,
    parameter int nr = 10
) (
    input  logic                 in_clk,
    input  logic                 rst,
    input  logic [32*nb-1:0]     from_Real_msg,
    input  logic [32*nk-1:0]     from_Real_key,
    input  logic                 Miso,
    output logic                 cs_enc_dec,
    output logic                 Mosi,
    output logic                 out_clk,
    output logic [32*nb-1:0]     Sipo_Register,
    output logic [2:0]           state_dbg
);

    localparam int BLK_W = 32 * nb;
    localparam int TX_W  = BLK_W + 32 * nk;

    localparam logic [10:0] IDLE_LAST = 11'd3;
    localparam logic [10:0] SEND_LAST = 11'(TX_W - 1);
    localparam logic [10:0] WAIT_LAST = 11'd1023;
    localparam logic [10:0] RECV_LAST = 11'(BLK_W - 1);

    // The round count does not affect master timing; it only has to agree
    // with the slave, so reject inconsistent AES configurations at elaboration.
    if (nb != 4 || nr != nk + 6) begin : g_bad_cfg
        $error("aes_spi_master: unsupported nk/nb/nr combination");
    end

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state;
    logic [10:0]         cnt;
    logic [TX_W-1:0]     tx_shift;
    logic [BLK_W-1:0]    rx_shift;

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            tx_shift      <= '0;
            rx_shift      <= '0;
            cs_enc_dec    <= 1'b1;
            Mosi          <= 1'b0;
            Sipo_Register <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cs_enc_dec <= 1'b1;
                    Mosi       <= 1'b0;
                    if (cnt == IDLE_LAST) begin
                        // The first bit goes straight to Mosi, so the shifter
                        // keeps only the remaining bits, already left-aligned.
                        tx_shift   <= {from_Real_msg[BLK_W-2:0], from_Real_key, 1'b0};
                        Mosi       <= from_Real_msg[BLK_W-1];
                        cs_enc_dec <= 1'b0;
                        cnt        <= '0;
                        state      <= ST_SEND;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                ST_SEND: begin
                    if (cnt == SEND_LAST) begin
                        Mosi  <= 1'b0;
                        cnt   <= '0;
                        state <= ST_WAIT;
                    end else begin
                        Mosi     <= tx_shift[TX_W-1];
                        tx_shift <= {tx_shift[TX_W-2:0], 1'b0};
                        cnt      <= cnt + 11'd1;
                    end
                end
                ST_WAIT: begin
                    if (Miso) begin
                        cnt   <= '0;
                        state <= ST_RECV;
                    end else if (cnt == WAIT_LAST) begin
                        // Slave never answered: abandon, keep old result.
                        cnt        <= '0;
                        cs_enc_dec <= 1'b1;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                ST_RECV: begin
                    rx_shift <= {rx_shift[BLK_W-2:0], Miso};
                    if (cnt == RECV_LAST) begin
                        // Publish together with cs rising so the result is
                        // already valid during the DONE cycle.
                        Sipo_Register <= {rx_shift[BLK_W-2:0], Miso};
                        cs_enc_dec    <= 1'b1;
                        cnt           <= '0;
                        state         <= ST_DONE;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                ST_DONE: begin
                    cs_enc_dec <= 1'b1;
                    Mosi       <= 1'b0;
                    cnt        <= '0;
                    state      <= ST_IDLE;
                end
                default: begin
                    cs_enc_dec <= 1'b1;
                    Mosi       <= 1'b0;
                    cnt        <= '0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_clk   = in_clk & ~cs_enc_dec;
    assign state_dbg = state;

endmodule

// File: tb/tb_aes_spi_master.sv
// Bench for aes_spi_master (nk=4). A slave agent answers each transfer with a
// bench-chosen result after a bench-chosen latency. The driver pushes, per
// transaction, the expected Mosi stream, the expected Sipo_Register after the
// transaction and the expected chip-select-low length; monitors pop and compare.
module tb_aes_spi_master;

  localparam int TXW     = 256;
  localparam int TIMEOUT = 1024;

  logic         in_clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] msg = '0;
  logic [127:0] key = '0;
  logic         miso = 1'b0;
  logic         cs_enc_dec;
  logic         mosi;
  logic         out_clk;
  logic [127:0] sipo;
  logic [2:0]   state_dbg;

  always #5 in_clk = ~in_clk;

  aes_spi_master #(.nk(4), .nb(4), .nr(10)) dut (
    .in_clk        (in_clk),
    .rst           (rst),
    .from_Real_msg (msg),
    .from_Real_key (key),
    .Miso          (miso),
    .cs_enc_dec    (cs_enc_dec),
    .Mosi          (mosi),
    .out_clk       (out_clk),
    .Sipo_Register (sipo),
    .state_dbg     (state_dbg)
  );

  int checks = 0;
  int errors = 0;

  logic [TXW-1:0] exp_q[$];
  logic [127:0]   exp_rx_q[$];
  int             exp_len_q[$];

  function automatic void check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- slave agent ----------------
  bit           sl_respond = 1'b0;
  int           sl_lat = 1;
  logic [127:0] sl_result = '0;
  int           sl_cnt = 0;

  // sl_cnt counts chip-select-low cycles; cycles 1..256 carry Mosi, then the
  // slave stays silent sl_lat cycles (start bit on the last), then 128 bits.
  always @(negedge in_clk) begin
    if (cs_enc_dec !== 1'b0) begin
      sl_cnt = 0;
      miso   = 1'b0;
    end else begin
      sl_cnt++;
      if (sl_respond && sl_cnt == TXW + sl_lat)
        miso = 1'b1;
      else if (sl_respond && sl_cnt > TXW + sl_lat && sl_cnt <= TXW + sl_lat + 128)
        miso = sl_result[127 - (sl_cnt - TXW - sl_lat - 1)];
      else
        miso = 1'b0;
    end
  end

  // ---------------- monitors ----------------
  bit             mon_en = 1'b0;
  int             mon_bits = 0;
  int             low_len = 0;
  logic [TXW-1:0] mon_shift = '0;
  logic [127:0]   model_sipo = '0;
  logic           prev_cs = 1'b1;

  always @(negedge in_clk) begin
    if (mon_en) begin
      check("out_clk_low_phase", {255'd0, out_clk}, 256'd0);
      if (cs_enc_dec === 1'b0) begin
        low_len++;
        if (mon_bits < TXW) begin
          mon_shift = {mon_shift[TXW-2:0], mosi};
          mon_bits++;
          if (mon_bits == TXW) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL mosi_stream: actual=%h required=none", mon_shift);
            end else begin
              check("mosi_stream", mon_shift, exp_q.pop_front());
            end
          end
        end
      end else begin
        if (prev_cs === 1'b1)
          check("mosi_idle", {255'd0, mosi}, 256'd0);
        if (prev_cs === 1'b0) begin
          int len;
          if (exp_rx_q.size() == 0 || exp_len_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL txn_end: actual=unexpected cs rise required=none");
          end else begin
            model_sipo = exp_rx_q.pop_front();
            len = exp_len_q.pop_front();
            if (len >= 0)
              check("cs_low_length", 256'(low_len), 256'(len));
          end
        end
        mon_bits = 0;
        low_len  = 0;
      end
      check("sipo_value", {128'd0, sipo}, {128'd0, model_sipo});
      prev_cs = cs_enc_dec;
    end
  end

  always @(posedge in_clk) begin
    if (mon_en) begin
      #2;
      check("out_clk_high_phase", {255'd0, out_clk}, {255'd0, ~cs_enc_dec});
    end
  end

  // ---------------- driver ----------------
  logic [127:0] drv_sipo = '0;

  // Called at a negedge while chip select is high and before the IDLE latch.
  task automatic run_txn(input bit set_new, input logic [127:0] m, input logic [127:0] k,
                         input bit resp, input int lat, input logic [127:0] res,
                         input int change_at, input int rst_at, input int exp_fall);
    int cyc;
    if (set_new) begin
      msg = m;
      key = k;
    end
    sl_respond = resp;
    sl_lat     = lat;
    sl_result  = res;
    exp_q.push_back({msg, key});
    if (rst_at > 0)
      drv_sipo = '0;
    else if (resp)
      drv_sipo = res;
    exp_rx_q.push_back(drv_sipo);
    exp_len_q.push_back(rst_at > 0 ? -1 : (resp ? TXW + lat + 128 : TXW + TIMEOUT));

    cyc = 0;
    while (cs_enc_dec !== 1'b0 && cyc < 20) begin
      @(negedge in_clk);
      cyc++;
    end
    check("cs_fall_delay", 256'(cyc), 256'(exp_fall));

    cyc = 0;
    while (cs_enc_dec === 1'b0 && cyc < 2000) begin
      @(negedge in_clk);
      cyc++;
      if (cyc == change_at)
        msg = rand128();
      rst = (cyc == rst_at);
    end
    rst = 1'b0;
    if (cs_enc_dec !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL cs_rise: actual=no rise within %0d cycles required=rise", cyc);
    end
    if (rst_at > 0) begin
      check("rst_abort_cycle", 256'(cyc), 256'(rst_at + 1));
      check("rst_abort_cs", {255'd0, cs_enc_dec}, 256'd1);
      check("rst_abort_sipo", {128'd0, sipo}, 256'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst = 1'b1;
    msg = 128'h8000_0001_C0DE_0000_FFFF_0000_1234_5678;
    key = 128'h8123_4567_89AB_CDEF_0011_2233_4455_6677;
    @(posedge in_clk);
    mon_en = 1'b1;
    repeat (10) begin
      @(negedge in_clk);
      check("reset_cs", {255'd0, cs_enc_dec}, 256'd1);
      check("reset_mosi", {255'd0, mosi}, 256'd0);
      check("reset_sipo", {128'd0, sipo}, 256'd0);
      check("reset_state", {253'd0, state_dbg}, 256'd0);
    end
    rst = 1'b0;

    // directed send + receive, slave answers 20 cycles into WAIT
    run_txn(1'b1, msg, key, 1'b1, 20, 128'h69C4E0D86A7B0430D8CDB78070B4C55A, 0, 0, 4);
    check("directed_result", {128'd0, sipo}, {128'd0, 128'h69C4E0D86A7B0430D8CDB78070B4C55A});

    // timeout: slave never answers, result must survive
    run_txn(1'b1, rand128(), rand128(), 1'b0, 1, rand128(), 0, 0, 5);
    check("timeout_keeps_sipo", {128'd0, sipo}, {128'd0, 128'h69C4E0D86A7B0430D8CDB78070B4C55A});

    // message changed mid-SEND, then carried into the next transfer
    lat = $urandom_range(1, 200);
    run_txn(1'b1, rand128(), rand128(), 1'b1, lat, rand128(), 40, 0, 4);
    lat = $urandom_range(1, 200);
    run_txn(1'b0, msg, key, 1'b1, lat, rand128(), 0, 0, 5);

    // reset while receiving
    run_txn(1'b1, rand128(), rand128(), 1'b1, 30, rand128(), 0, TXW + 30 + 50, 5);

    // random traffic
    for (int i = 0; i < 6; i++) begin
      lat = $urandom_range(1, 200);
      run_txn(1'b1, rand128(), rand128(), 1'b1, lat, rand128(), 0, 0, (i == 0) ? 4 : 5);
    end

    repeat (3) @(negedge in_clk);
    check("exp_q_drained", 256'(exp_q.size()), 256'd0);
    check("exp_rx_q_drained", 256'(exp_rx_q.size()), 256'd0);
    check("exp_len_q_drained", 256'(exp_len_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
